// File: rtl/mfcc_pkg.sv
// Shared types and constants for the front-end sample pipeline:
// the Q1.15 sample type, the fixed-point shift, the default
// de-emphasis coefficient and the de_emphasis FSM state encoding.
package mfcc_pkg;

   typedef logic signed [15:0] sample_t;

   localparam int      Q15_SHIFT     = 15;
   localparam sample_t DEFAULT_ALPHA = 16'sd31785;  // 0.97 in Q1.15

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_ADD  = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

endpackage : mfcc_pkg

// File: rtl/q15_mac.sv
// Q1.15 multiply / shift / add / reduce datapath for de_emphasis.
// prod_o = mul_a_i * COEF (full 32-bit signed product).
// sum_o  = add_x_i + (prod_i >>> 15), formed at 17 bits and reduced to 16.
// Optional macro DE_EMPHASIS_SAT_EN: clamp the 17-bit sum to the 16-bit
// range. When it is undefined the sum wraps (keeps its low 16 bits).
module q15_mac
   import mfcc_pkg::*;
#(
   parameter sample_t COEF = DEFAULT_ALPHA
) (
   input  sample_t             mul_a_i,
   output logic signed [31:0]  prod_o,
   input  sample_t             add_x_i,
   input  logic signed [31:0]  prod_i,
   output sample_t             sum_o
);

   logic signed [31:0] a_ext;
   logic signed [31:0] c_ext;
   logic signed [31:0] prod_sh;
   logic signed [16:0] prod_sh17;
   logic signed [16:0] x_ext;
   logic signed [16:0] sum17;

   assign a_ext  = 32'(mul_a_i);
   assign c_ext  = 32'(COEF);
   assign prod_o = a_ext * c_ext;

   // Arithmetic shift floors toward minus infinity; the top 17 bits of the
   // shifted product always hold the full value for 16x16 operands.
   assign prod_sh   = prod_i >>> Q15_SHIFT;
   assign prod_sh17 = prod_sh[16:0];
   assign x_ext     = 17'(add_x_i);
   assign sum17     = x_ext + prod_sh17;

   // Reduce the 17-bit sum to a 16-bit sample.
   always_comb begin
`ifdef DE_EMPHASIS_SAT_EN
      if (sum17 > 17'sd32767) begin
         sum_o = 16'sh7FFF;
      end else if (sum17 < -17'sd32768) begin
         sum_o = 16'sh8000;
      end else begin
         sum_o = sum17[15:0];
      end
`else
      sum_o = sum17[15:0];
`endif
   end

endmodule : q15_mac

// File: rtl/de_emphasis.sv
// De-emphasis IIR filter: y[n] = x[n] + ALPHA * y[n-1], Q1.15.
// One sample in flight at a time, sequenced by a four-state FSM; the
// arithmetic lives in q15_mac. in_first (or reset) drops the feedback
// history. Optional macro DE_EMPHASIS_SAT_EN selects a saturating sum
// instead of two's-complement wrap (handled inside q15_mac).
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_IDLE | in_ready=1, waiting for in_valid; captures x_in/in_first
//   ST_MUL  | registers prod = y_prev * ALPHA (y_prev=0 on first)
//   ST_ADD  | loads reduced sum into y_out and y_prev, raises out_valid
//   ST_OUT  | holds out_valid/y_out until out_ready
module de_emphasis
   import mfcc_pkg::*;
#(
   parameter logic signed [15:0] ALPHA = DEFAULT_ALPHA
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_first,
   input  logic signed [15:0] x_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [15:0] y_out
);

   state_t             state_q, state_d;
   sample_t            x_q;
   logic               first_q;
   sample_t            y_prev_q;
   logic signed [31:0] prod_q;
   sample_t            y_out_q;
   logic               out_valid_q;

   sample_t            mac_a;
   logic signed [31:0] mac_prod;
   sample_t            mac_sum;

   assign mac_a = first_q ? '0 : y_prev_q;

   q15_mac #(
      .COEF    (ALPHA)
   ) u_mac (
      .mul_a_i (mac_a),
      .prod_o  (mac_prod),
      .add_x_i (x_q),
      .prod_i  (prod_q),
      .sum_o   (mac_sum)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)  state_d = ST_MUL;
         ST_MUL:                 state_d = ST_ADD;
         ST_ADD:                 state_d = ST_OUT;
         ST_OUT:  if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      in_ready = (state_q == ST_IDLE);
   end

   // Datapath registers, advanced by the current state.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q         <= '0;
         first_q     <= 1'b0;
         y_prev_q    <= '0;
         prod_q      <= '0;
         y_out_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  x_q     <= x_in;
                  first_q <= in_first;
               end
            end
            ST_MUL: begin
               prod_q <= mac_prod;
            end
            ST_ADD: begin
               y_out_q     <= mac_sum;
               y_prev_q    <= mac_sum;
               out_valid_q <= 1'b1;
            end
            ST_OUT: begin
               if (out_ready) out_valid_q <= 1'b0;
            end
            default: begin
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign y_out     = y_out_q;

endmodule : de_emphasis

// File: tb/tb_de_emphasis.sv
// Self-checking bench for de_emphasis: directed impulse / saturation /
// truncation / backpressure / restart / reset scenarios plus randomized
// traffic, all checked against an arithmetic reference of the recurrence.
module tb_de_emphasis;

   localparam longint ALPHA = 31785;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic               in_first;
   logic signed [15:0] x_in;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] y_out;

   int checks;
   int failures;
   int model_yprev;

   de_emphasis dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_first  (in_first),
      .x_in      (x_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y_out     (y_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: y = x + floor(ALPHA*yprev / 2^15), then clamp or wrap.
   function automatic int ref_y(input int x, input int yprev, input bit first);
      longint p;
      longint s;
      p = first ? 64'sd0 : longint'(yprev) * ALPHA;
      s = longint'(x) + (p >>> 15);
`ifdef DE_EMPHASIS_SAT_EN
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
`else
      s = s & 64'sd65535;
      if (s > 32767) s = s - 65536;
`endif
      return int'(s);
   endfunction

   // Push one sample through with 'stall' extra cycles of out_ready=0 in OUT,
   // checking the handshake protocol along the way; returns the delivered y.
   task automatic run_sample(input int x, input bit first, input int stall,
                             output int y);
      int n;
      int yh;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL in_ready_idle got=%b exp=1", in_ready);
      end
      in_valid  = 1'b1;
      x_in      = 16'(x);
      in_first  = first;
      out_ready = (stall == 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_first = 1'b1;
      x_in     = 16'($urandom);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!out_valid) begin
            checks++;
            if (in_ready !== 1'b0) begin
               failures++;
               $display("FAIL in_ready_busy got=%b exp=0 cyc=%0d", in_ready, n);
            end
         end
      end while (!out_valid && n < 10);
      checks++;
      if (n != 3 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL latency got=%0d exp=3 (out_valid=%b)", n, out_valid);
      end
      yh = int'(y_out);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || int'(y_out) != yh || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold got ov=%b y=%0d rdy=%b exp ov=1 y=%0d rdy=0",
                     out_valid, y_out, in_ready, yh);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || int'(y_out) != yh || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL release got ov=%b y=%0d rdy=%b exp ov=0 y=%0d rdy=1",
                  out_valid, y_out, in_ready, yh);
      end
      y = yh;
   endtask

   // Run one sample and compare with the reference, advancing the model.
   task automatic check_sample(input string name, input int x, input bit first,
                               input int stall);
      int y;
      int exp_y;
      exp_y = ref_y(x, model_yprev, first);
      run_sample(x, first, stall, y);
      checks++;
      if (y != exp_y) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, y, exp_y);
      end
      model_yprev = exp_y;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      x_in     = 16'sd777;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || y_out !== 16'sd0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state got ov=%b y=%0d rdy=%b exp ov=0 y=0 rdy=1",
                  out_valid, y_out, in_ready);
      end
      in_valid = 1'b0;
      rst      = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_ignore_valid got rdy=%b ov=%b exp rdy=1 ov=0",
                  in_ready, out_valid);
      end
      model_yprev = 0;
   endtask

   task automatic test_impulse;
      int y;
      check_sample("impulse0", 16384, 1'b1, 0);
      check_sample("impulse1", 0, 1'b0, 0);
      check_sample("impulse2", 0, 1'b0, 0);
      // independent absolute check of the known impulse tail
      checks++;
      if (model_yprev != 15415) begin
         failures++;
         $display("FAIL impulse_ref got=%0d exp=15415", model_yprev);
      end
      run_sample(0, 1'b1, 0, y);
      checks++;
      if (y != 0) begin
         failures++;
         $display("FAIL impulse_clear got=%0d exp=0", y);
      end
      model_yprev = 0;
   endtask

   task automatic test_saturation;
      int y0;
      int y1;
      run_sample(32767, 1'b1, 0, y0);
      run_sample(32767, 1'b0, 0, y1);
      checks++;
`ifdef DE_EMPHASIS_SAT_EN
      if (y0 != 32767 || y1 != 32767) begin
         failures++;
         $display("FAIL saturation got=%0d,%0d exp=32767,32767", y0, y1);
      end
`else
      if (y0 != 32767 || y1 != -985) begin
         failures++;
         $display("FAIL wrap got=%0d,%0d exp=32767,-985", y0, y1);
      end
`endif
      model_yprev = y1;
   endtask

   task automatic test_neg_trunc;
      int y0;
      int y1;
      run_sample(-1, 1'b1, 0, y0);
      run_sample(0, 1'b0, 0, y1);
      checks++;
      if (y0 != -1 || y1 != -1) begin
         failures++;
         $display("FAIL neg_trunc got=%0d,%0d exp=-1,-1", y0, y1);
      end
      model_yprev = -1;
   endtask

   task automatic test_backpressure;
      check_sample("bp_first", 12000, 1'b1, 5);
      check_sample("bp_next", -3000, 1'b0, 5);
   endtask

   task automatic test_frame_restart;
      int y;
      check_sample("restart_a", 16384, 1'b1, 0);
      check_sample("restart_b", 0, 1'b0, 0);
      run_sample(100, 1'b1, 0, y);
      checks++;
      if (y != 100) begin
         failures++;
         $display("FAIL frame_restart got=%0d exp=100", y);
      end
      model_yprev = 100;
      check_sample("restart_tail", 0, 1'b0, 0);
   endtask

   task automatic test_reset_mid_op;
      int y;
      int bad;
      // reset while in MUL
      check_sample("pre_reset", 5000, 1'b1, 0);
      @(negedge clk);
      in_valid = 1'b1;
      x_in     = 16'sd1234;
      in_first = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || y_out !== 16'sd0) begin
         failures++;
         $display("FAIL reset_mul got ov=%b y=%0d exp ov=0 y=0", out_valid, y_out);
      end
      rst = 1'b0;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL stale_output got=%0d exp=0", bad);
      end
      run_sample(200, 1'b0, 0, y);
      checks++;
      if (y != 200) begin
         failures++;
         $display("FAIL after_reset_mul got=%0d exp=200", y);
      end
      // reset while holding a result in OUT
      @(negedge clk);
      in_valid  = 1'b1;
      x_in      = 16'sd4321;
      in_first  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL reach_out got=%b exp=1", out_valid);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || y_out !== 16'sd0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_out got ov=%b y=%0d rdy=%b exp ov=0 y=0 rdy=1",
                  out_valid, y_out, in_ready);
      end
      rst       = 1'b0;
      out_ready = 1'b1;
      model_yprev = 0;
      check_sample("after_reset_out", 300, 1'b0, 0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         int  x;
         bit  first;
         int  stall;
         x     = int'(16'($urandom)) - 32768;
         first = ($urandom_range(0, 7) == 0);
         stall = int'($urandom_range(0, 3));
         check_sample("random", x, first, stall);
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      model_yprev = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_first    = 1'b0;
      x_in        = '0;
      out_ready   = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      test_impulse();
      test_saturation();
      test_neg_trunc();
      test_backpressure();
      test_frame_restart();
      test_reset_mid_op();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

endmodule : tb_de_emphasis

// File: doc/de_emphasis.md
DE_EMPHASIS -- requirements
Module: de_emphasis

Interface
REQ-001 SHALL have parameter ALPHA, signed 16-bit, default 31785 (0.97 in Q1.15), the feedback coefficient.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, asserted when x_in holds a sample.
REQ-005 SHALL have port in_ready, output, 1, high when the block can accept a sample.
REQ-006 SHALL have port in_first, input, 1, qualified by in_valid; marks the first sample of a frame.
REQ-007 SHALL have port x_in, input, signed 16, the pre-emphasized sample x[n], Q1.15.
REQ-008 SHALL have port out_valid, output, 1, asserted when y_out holds a result.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts y_out.
REQ-010 SHALL have port y_out, output, signed 16, the restored sample y[n] = x[n] + ALPHA*y[n-1], Q1.15.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, ADD and OUT.
REQ-012 IDLE SHALL drive in_ready=1, and all other states SHALL drive in_ready=0.
REQ-013 In IDLE with in_valid=1, SHALL capture x_in and in_first and go to MUL; otherwise SHALL stay in IDLE.
REQ-014 MUL SHALL register prod = y_prev*ALPHA (32-bit signed), with y_prev forced to 0 when captured in_first=1, then go to ADD.
REQ-015 ADD SHALL compute sum = x + (prod >>> 15) at 17 bits (arithmetic shift, truncation toward minus infinity), then go to OUT.
REQ-016 ADD SHALL reduce sum to 16 bits per REQ-025/026 and load the result into both y_out and y_prev.
REQ-017 ADD SHALL set out_valid=1.
REQ-018 OUT SHALL hold out_valid=1 and keep y_out stable until out_ready=1.
REQ-019 On the OUT edge with out_ready=1, SHALL clear out_valid and go to IDLE.
REQ-020 Latency SHALL be 3 edges from the input handshake edge to out_valid high; peak throughput SHALL be one sample per 4 cycles.
REQ-021 y_out SHALL retain its last value after out_valid falls.
REQ-022 If in_first arrives mid-frame, SHALL discard the feedback history and keep no other state.

Reset
REQ-023 With rst=1 at an edge, SHALL set state=IDLE, out_valid=0, y_out=0, y_prev=0, prod=0, and ignore in_valid that cycle.
REQ-024 Reset asserted in any state, including OUT with out_valid=1, SHALL abort the operation with no output handshake, and the first sample after reset SHALL behave as in_first=1.

Configuration
REQ-025 With macro DE_EMPHASIS_SAT_EN defined, SHALL clamp sum to [-32768, 32767].
REQ-026 Without DE_EMPHASIS_SAT_EN, SHALL truncate sum to its low 16 bits (two's-complement wrap).

Structure
REQ-027 Shared package mfcc_pkg SHALL hold the sample_t typedef (signed 16), the Q15_SHIFT=15 constant, the DEFAULT_ALPHA=31785 constant and the FSM state enum.
REQ-028 Multiply-shift-add-saturate SHALL be a sub-module q15_mac, with the FSM and registers in de_emphasis.

Verification
REQ-029 Impulse test: x=16384 (first), then 0, 0 -> y = 16384, 15892, 15415.
REQ-030 Saturation test: x=32767 (first), then 32767 -> y = 32767, 32767 with the macro, and 32767, -985 without it.
REQ-031 Negative truncation test: x=-1 (first), then 0 -> y = -1, -1, confirming the arithmetic shift.
REQ-032 Backpressure test: out_ready low for 5 cycles in OUT -> out_valid and y_out stable, in_ready=0 throughout, and a single result delivered on release.
REQ-033 Frame restart test: after y=15892, apply x=100 with in_first=1 -> y=100 (history dropped).
REQ-034 Reset test: rst in MUL, then x=200 -> y=200, out_valid=0 during reset, and no stale output.
